// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings and FSM states for the MEM-stage data memory
package dm_pkg;
    typedef enum logic [2:0] {
        OP_W  = 3'd0,
        OP_HS = 3'd1,
        OP_HU = 3'd2,
        OP_BS = 3'd3,
        OP_BU = 3'd4
    } op_e;
    typedef enum logic [1:0] {
        EXC_NONE     = 2'd0,
        EXC_MISALIGN = 2'd1,
        EXC_RANGE    = 2'd2
    } exc_e;
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;
    function automatic logic is_half(input logic [2:0] op);
        return op == OP_HS || op == OP_HU;
    endfunction
    function automatic logic is_byte(input logic [2:0] op);
        return op == OP_BS || op == OP_BU;
    endfunction
endpackage

// File: rtl/dm_lane.sv
// dm_lane: byte-enable store merge and load lane extract with sign/zero extension
module dm_lane
    import dm_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);
    logic [3:0]  w_be;
    logic [31:0] w_wrep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    // store: replicate data across lanes and overwrite only the enabled bytes
    always_comb begin
        w_be     = is_byte(i_op) ? 4'b0001 << i_lane : is_half(i_op) ? (i_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_wrep   = is_byte(i_op) ? {4{i_wdata[7:0]}} : is_half(i_op) ? {2{i_wdata[15:0]}} : i_wdata;
        o_merged = i_word;
        for (int i = 0; i < 4; i++)
            if (w_be[i]) o_merged[8*i +: 8] = w_wrep[8*i +: 8];
    end
    // load: pick the addressed lane and extend according to the op
    always_comb begin
        w_byte  = i_word[{i_lane, 3'b000} +: 8];
        w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_rdata = is_byte(i_op) ? {{24{i_op == OP_BS && w_byte[7]}}, w_byte}
                : is_half(i_op) ? {{16{i_op == OP_HS && w_half[15]}}, w_half}
                : i_word;
    end
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data memory with clear sweep, sub-word access and exceptions; DM_WRITE_LOG_EN enables store logging
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_exc
);
    localparam int          IW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    state_e        r_state, w_next;
    logic [IW-1:0] r_clr_cnt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic          r_rsp_valid;
    logic [31:0]   r_rsp_rdata;
    exc_e          r_rsp_exc, w_exc;
    logic [31:0]   w_off, w_word, w_merged, w_rdata;
    logic [IW-1:0] w_idx;
    logic          w_acc, w_mis;

    assign w_off  = req_addr - BASE_ADDR;
    assign w_idx  = w_off[IW+1:2];
    assign w_acc  = req_valid && req_ready;
    assign w_word = r_mem[w_idx];

    dm_lane u_lane (
        .i_op     (req_op),
        .i_lane   (w_off[1:0]),
        .i_wdata  (req_wdata),
        .i_word   (w_word),
        .o_merged (w_merged),
        .o_rdata  (w_rdata)
    );

    // misalignment outranks the range check
    always_comb begin
        w_mis = is_half(req_op) ? w_off[0] : !is_byte(req_op) && w_off[1:0] != 2'b00;
        w_exc = w_mis ? EXC_MISALIGN : ({1'b0, w_off} >= LIMIT) ? EXC_RANGE : EXC_NONE;
    end

    // state register and sweep counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + IW'(1);
        end
    end

    // leave CLEAR once the last word has been zeroed
    always_comb begin
        w_next = (r_state == ST_CLEAR && r_clr_cnt == IW'(DEPTH_WORDS - 1)) ? ST_RUN : r_state;
    end

    // requests are only taken once the sweep is done
    always_comb begin
        req_ready = r_state == ST_RUN;
    end

    // array writes: sweep zeroes during CLEAR, merged stores during RUN
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_acc && req_we && w_exc == EXC_NONE) begin
            r_mem[w_idx] <= w_merged;
`ifdef DM_WRITE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, w_merged);
`endif
        end
    end

`ifndef DM_WRITE_LOG_EN
    logic w_unused_pc;
    assign w_unused_pc = ^req_pc;
`endif

    // one-cycle registered response; async reset drops any in-flight pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_exc   <= EXC_NONE;
        end else begin
            r_rsp_valid <= w_acc;
            r_rsp_rdata <= (w_acc && !req_we && w_exc == EXC_NONE) ? w_rdata : '0;
            r_rsp_exc   <= w_acc ? w_exc : EXC_NONE;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_exc   = r_rsp_exc;
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed checks of clear sweep, sub-word access, exceptions and reset behaviour
module tb_dm_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_pc = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;

    int n_tests = 0;
    int n_fail  = 0;

    logic        g_valid;
    logic [31:0] g_rdata;
    logic [1:0]  g_exc;

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  exc;
    } vec_t;

    always #5 clk = ~clk;

    dm_ctrl #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_exc   (rsp_exc)
    );

    task automatic req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0040_0000 + addr;
        @(posedge clk);
        #1;
        g_valid   = rsp_valid;
        g_rdata   = rsp_rdata;
        g_exc     = rsp_exc;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_exc !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h exc=%0d, want 0 0 0 0", req_ready, rsp_valid, rsp_rdata, rsp_exc);
        end
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0000_DEAD;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (req_ready !== 1'(k == 16) || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_cycle_%0d: ready=%b valid=%b, want ready=%b valid=0", k, req_ready, rsp_valid, 1'(k == 16));
            end
        end
        req_valid = 1'b0;
        req(1'b0, 3'd0, 32'h3C, 32'h0);
        n_tests++;
        if (g_valid !== 1'b1 || g_rdata !== 32'h0 || g_exc !== 2'd0) begin
            n_fail++;
            $display("FAIL lw_after_clear: valid=%b rdata=%h exc=%0d, want 1 00000000 0", g_valid, g_rdata, g_exc);
        end
    endtask

    task automatic test_store_load();
        vec_t v[$];
        v.push_back('{1'b1, 3'd0, 32'h08, 32'h1234_5678, 32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd3, 32'h09, 32'h0,         32'h0000_0056, 2'd0});
        v.push_back('{1'b0, 3'd4, 32'h0B, 32'h0,         32'h0000_0012, 2'd0});
        v.push_back('{1'b0, 3'd1, 32'h0A, 32'h0,         32'h0000_1234, 2'd0});
        v.push_back('{1'b0, 3'd2, 32'h08, 32'h0,         32'h0000_5678, 2'd0});
        foreach (v[i]) begin
            req(v[i].we, v[i].op, v[i].addr, v[i].wdata);
            n_tests++;
            if (g_valid !== 1'b1 || g_rdata !== v[i].rdata || g_exc !== v[i].exc) begin
                n_fail++;
                $display("FAIL store_load_%0d: valid=%b rdata=%h exc=%0d, want 1 %h %0d", i, g_valid, g_rdata, g_exc, v[i].rdata, v[i].exc);
            end
        end
    endtask

    task automatic test_subword_store();
        vec_t v[$];
        v.push_back('{1'b1, 3'd0, 32'h04, 32'h0000_0000, 32'h0000_0000, 2'd0});
        v.push_back('{1'b1, 3'd3, 32'h05, 32'h0000_00FF, 32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd0, 32'h04, 32'h0,         32'h0000_FF00, 2'd0});
        v.push_back('{1'b0, 3'd3, 32'h05, 32'h0,         32'hFFFF_FFFF, 2'd0});
        v.push_back('{1'b0, 3'd2, 32'h04, 32'h0,         32'h0000_FF00, 2'd0});
        v.push_back('{1'b1, 3'd1, 32'h06, 32'hAAAA_8001, 32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd0, 32'h04, 32'h0,         32'h8001_FF00, 2'd0});
        v.push_back('{1'b0, 3'd1, 32'h06, 32'h0,         32'hFFFF_8001, 2'd0});
        v.push_back('{1'b0, 3'd4, 32'h07, 32'h0,         32'h0000_0080, 2'd0});
        foreach (v[i]) begin
            req(v[i].we, v[i].op, v[i].addr, v[i].wdata);
            n_tests++;
            if (g_valid !== 1'b1 || g_rdata !== v[i].rdata || g_exc !== v[i].exc) begin
                n_fail++;
                $display("FAIL subword_%0d: valid=%b rdata=%h exc=%0d, want 1 %h %0d", i, g_valid, g_rdata, g_exc, v[i].rdata, v[i].exc);
            end
        end
    endtask

    task automatic test_exceptions();
        vec_t v[$];
        v.push_back('{1'b0, 3'd0, 32'h00, 32'h0,         32'h0000_0000, 2'd0});
        v.push_back('{1'b1, 3'd1, 32'h03, 32'h0000_BEEF, 32'h0000_0000, 2'd1});
        v.push_back('{1'b0, 3'd0, 32'h00, 32'h0,         32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd0, 32'h40, 32'h0,         32'h0000_0000, 2'd2});
        v.push_back('{1'b0, 3'd0, 32'h0A, 32'h0,         32'h0000_0000, 2'd1});
        v.push_back('{1'b0, 3'd1, 32'h41, 32'h0,         32'h0000_0000, 2'd1});
        v.push_back('{1'b1, 3'd0, 32'h40, 32'h0000_0001, 32'h0000_0000, 2'd2});
        v.push_back('{1'b0, 3'd3, 32'h3F, 32'h0,         32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd2, 32'h3E, 32'h0,         32'h0000_0000, 2'd0});
        v.push_back('{1'b0, 3'd0, 32'h08, 32'h0,         32'h1234_5678, 2'd0});
        foreach (v[i]) begin
            req(v[i].we, v[i].op, v[i].addr, v[i].wdata);
            n_tests++;
            if (g_valid !== 1'b1 || g_rdata !== v[i].rdata || g_exc !== v[i].exc) begin
                n_fail++;
                $display("FAIL exception_%0d: valid=%b rdata=%h exc=%0d, want 1 %h %0d", i, g_valid, g_rdata, g_exc, v[i].rdata, v[i].exc);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = 3'd0;
        req_addr  = 32'h0C;
        req_wdata = 32'h0000_000A;
        @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_exc !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_store: valid=%b rdata=%h exc=%0d, want 1 00000000 0", rsp_valid, rsp_rdata, rsp_exc);
        end
        req_we    = 1'b0;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_000A || rsp_exc !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_load: valid=%b rdata=%h exc=%0d, want 1 0000000a 0", rsp_valid, rsp_rdata, rsp_exc);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        req(1'b1, 3'd0, 32'h00, 32'h0000_0055);
        n_tests++;
        if (g_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_store_accept: valid=%b, want 1", g_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: valid=%b ready=%b, want 0 0", rsp_valid, req_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        while (req_ready !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc != 16) begin
            n_fail++;
            $display("FAIL mid_sweep_len: cycles=%0d, want 16", cyc);
        end
        req(1'b0, 3'd0, 32'h00, 32'h0);
        n_tests++;
        if (g_valid !== 1'b1 || g_rdata !== 32'h0 || g_exc !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_cleared: valid=%b rdata=%h exc=%0d, want 1 00000000 0", g_valid, g_rdata, g_exc);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_subword_store();
        test_exceptions();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data memory for the pipelined MIPS core, sitting in the MEM stage. It replaces the fixed word-only DM with byte/halfword stores, sign/zero-extended loads, a one-cycle registered response, and alignment/range exceptions. After reset it clears its array with an internal sweep state machine and holds off requests until the sweep is done.

## Interface
Parameters:
- `DEPTH_WORDS`, 3072: number of 32-bit words; must be a power of two or 3072.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; `reset`==0 forces the reset state immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_op`  in  3  0 = word, 1 = half signed, 2 = half unsigned, 3 = byte signed, 4 = byte unsigned. Stores use 0, 1 or 3.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low bits for byte/half.
- `req_pc`  in  32  PC of the requesting instruction; used only for logging.
- `rsp_valid`  out  1  response for the request accepted in the previous cycle.
- `rsp_rdata`  out  32  extended load data; 0 for stores and for exceptions.
- `rsp_exc`  out  2  0 = none, 1 = misaligned, 2 = out of range.

## Operation
- FSM states:
  - CLEAR: writes 0 to word `clr_cnt` each cycle and increments `clr_cnt`. Goes to RUN after word DEPTH_WORDS-1 is written.
  - RUN: serves requests.
- `req_ready` = (state == RUN). A request is accepted on a rising edge with `req_valid` && `req_ready`.
- Offset `off` = `req_addr` - `BASE_ADDR`, 32-bit wrap. Word index = `off`[31:2]. Lane = `off`[1:0], little-endian.
- Exception priority:
  - Misaligned (exc 1): word op with `off`[1:0] != 0, or half op with `off`[0] != 0.
  - Out of range (exc 2): otherwise, when `off` >= DEPTH_WORDS*4.
  - On either exception, no array write and `rsp_rdata` = 0.
- Store: byte-enable merge into the addressed word at the accept edge. Half uses lanes {`off`[1],0}+1..0; byte uses lane `off`[1:0].
- Load: the word is read at the accept edge, then the lane is selected and extended. Op 1 and 3 sign-extend; op 2 and 4 zero-extend.
- Every accepted request produces exactly one `rsp_valid` pulse. There is no response backpressure.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_exc`=0, state=CLEAR, `clr_cnt`=0.
- CLEAR lasts exactly DEPTH_WORDS cycles after `reset` deasserts. `req_ready` rises on cycle DEPTH_WORDS+1.
- Latency: a request accepted at edge N has its response valid from edge N to edge N+1.
- Throughput: one request per cycle.
- Back-to-back requests to the same word: a store at edge N is visible to a load accepted at edge N+1. No bypass is needed because the array write completes at N.
- Reset asserted mid-operation: the in-flight response is dropped (`rsp_valid`→0 asynchronously), a pending store not yet at an edge is lost, and the sweep restarts from word 0.
- Requests presented during CLEAR are ignored and produce no response.

## Configuration
- `DM_WRITE_LOG_EN`: each successful store issues $display("%d@%h: *%h <= %h", $time, req_pc, word-aligned byte address, merged word) at the write edge.
- Without the macro: no display, `req_pc` is unused, and the RTL is otherwise identical.

## Structure
- Package `dm_pkg`: `req_op` encodings, `rsp_exc` codes, and the FSM state enum (CLEAR, RUN).
- Sub-module `dm_lane`, combinational:
  - Store direction: byte-enable/merge generation.
  - Load direction: lane extract and sign/zero extension.
- `dm_ctrl` holds the FSM, clear counter, array, exception check and response register.

## Test plan
All scenarios use DEPTH_WORDS=16 and BASE_ADDR=0.
- Hold `reset`=0 for 3 cycles, then release → `req_ready`=0 for 16 cycles, 1 on cycle 17. lw @0x3C → `rsp_rdata`=0, `rsp_exc`=0.
- sw 0x12345678 @0x8, then lb @0x9 → 0x00000056; lbu @0xB → 0x00000012; lh @0xA → 0x00001234.
- sw 0 @0x4, sb 0xFF @0x5, then lw @0x4 → 0x0000FF00; lb @0x5 → 0xFFFFFFFF; lhu @0x4 → 0x0000FF00.
- sh 0xBEEF @0x3 → `rsp_exc`=1, after which lw @0x0 is unchanged. lw @0x40 → `rsp_exc`=2, `rsp_rdata`=0.
- Back-to-back: sw 0xA @0xC at edge N, lw @0xC at N+1 → `rsp_valid` high on two consecutive cycles, second `rsp_rdata`=0xA.
- Accept sw 0x55 @0x0, then assert `reset` before the next edge → `rsp_valid` drops at once. After the 16-cycle sweep, lw @0x0 → 0.
